// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: load tags, load results and grant encoding.
package mem_port_arbiter_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned ROB_IX_WIDTH = 3;

    typedef struct packed {
        logic                    valid;
        logic [ROB_IX_WIDTH-1:0] rob_ix;
    } load_tag_t;

    typedef struct packed {
        logic [ROB_IX_WIDTH-1:0] rob_ix;
        logic [XLEN-1:0]         data;
    } load_result_t;

    typedef enum logic [1:0] {
        GRANT_NONE  = 2'd0,
        GRANT_LOAD  = 2'd1,
        GRANT_STORE = 2'd2
    } mem_grant_e;

    // Pointer width that stays legal for a single-entry structure.
    function automatic int unsigned ptr_width(input int unsigned entries);
        return (entries <= 1) ? 1 : $clog2(entries);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_load_result_fifo.sv
// Show-ahead FIFO holding load results until the CDB accepts them.
module mem_port_arbiter_load_result_fifo
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  load_result_t     push_data,
    input  logic             pop,
    output logic             valid,
    output load_result_t     head,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);

    load_result_t     store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop = pop && (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            assert (!(push && !do_pop && (count_q == CNT_W'(DEPTH))))
                else $error("load_result_fifo overflow");
            if (push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            store_q[wr_ptr_q] <= push_data;
        end
    end

    assign valid = (count_q != '0);
    assign head  = store_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data BRAM port between speculative loads and committed stores,
// tracks loads through the BRAM read latency and queues their results for the CDB.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned READ_LATENCY      = 2,
    parameter int unsigned ADDR_WIDTH        = 12,
    parameter int unsigned RESULT_FIFO_DEPTH = 4,
    parameter int unsigned MAX_STORE_STREAK  = 3
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    lb_valid_in,
    input  logic [XLEN-1:0]         lb_addr_in,
    input  logic [ROB_IX_WIDTH-1:0] lb_rob_ix_in,
    output logic                    lb_read_out,
    input  logic                    st_valid_in,
    input  logic [XLEN-1:0]         st_addr_in,
    input  logic [XLEN-1:0]         st_data_in,
    output logic                    st_ack_out,
    input  logic                    flush_in,
    output logic [ADDR_WIDTH-1:0]   mem_addr_out,
    output logic                    mem_we_out,
    output logic [XLEN-1:0]         mem_wdata_out,
    input  logic [XLEN-1:0]         mem_rdata_in,
    output logic                    ld_valid_out,
    output logic [ROB_IX_WIDTH-1:0] ld_rob_ix_out,
    output logic [XLEN-1:0]         ld_data_out,
    input  logic                    ld_accept_in
);

    localparam int unsigned FIFO_CNT_W = $clog2(RESULT_FIFO_DEPTH + 1);
    localparam int unsigned CREDIT_W   = $clog2(RESULT_FIFO_DEPTH + READ_LATENCY + 1);
    localparam int unsigned STREAK_W   = $clog2(MAX_STORE_STREAK + 1);

    load_tag_t             tag_q [READ_LATENCY];
    logic [STREAK_W-1:0]   streak_q;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic [FIFO_CNT_W-1:0] fifo_cnt;
    logic                  fifo_valid;
    load_result_t          fifo_head;
    load_result_t          fifo_push_data;
    logic [CREDIT_W-1:0]   outstanding;
    logic                  load_eligible;
    mem_grant_e            grant;
    logic [ADDR_WIDTH-1:0] ld_word;
    logic [ADDR_WIDTH-1:0] st_word;
    logic                  unused_addr_bits;

    assign ld_word = lb_addr_in[ADDR_WIDTH+1:2];
    assign st_word = st_addr_in[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{lb_addr_in[XLEN-1:ADDR_WIDTH+2], lb_addr_in[1:0],
                                st_addr_in[XLEN-1:ADDR_WIDTH+2], st_addr_in[1:0]};

    // Loads in flight plus results buffered, as seen at the start of the cycle.
    always_comb begin
        outstanding = CREDIT_W'(fifo_cnt);
        for (int i = 0; i < READ_LATENCY; i++) begin
            outstanding = outstanding + CREDIT_W'(tag_q[i].valid);
        end
    end

    assign load_eligible = lb_valid_in && !flush_in && !rst_in
                           && (outstanding < CREDIT_W'(RESULT_FIFO_DEPTH));

    // Stores win unless the waiting load has already been passed over too often.
    always_comb begin
        grant = GRANT_NONE;
        if (st_valid_in && !rst_in
            && !(load_eligible && (streak_q == STREAK_W'(MAX_STORE_STREAK)))) begin
            grant = GRANT_STORE;
        end else if (load_eligible) begin
            grant = GRANT_LOAD;
        end
    end

    always_comb begin
        mem_addr_out  = last_addr_q;
        mem_we_out    = 1'b0;
        mem_wdata_out = '0;
        st_ack_out    = 1'b0;
        lb_read_out   = 1'b0;
        case (grant)
            GRANT_STORE: begin
                mem_addr_out  = st_word;
                mem_we_out    = 1'b1;
                mem_wdata_out = st_data_in;
                st_ack_out    = 1'b1;
            end
            GRANT_LOAD: begin
                mem_addr_out = ld_word;
                lb_read_out  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            streak_q <= '0;
        end else if (!load_eligible || (grant == GRANT_LOAD)) begin
            streak_q <= '0;
        end else if ((grant == GRANT_STORE) && (streak_q != STREAK_W'(MAX_STORE_STREAK))) begin
            streak_q <= streak_q + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_addr_q <= '0;
        end else if (grant != GRANT_NONE) begin
            last_addr_q <= mem_addr_out;
        end
    end

    // Tag pipeline mirrors the BRAM read latency; the last stage marks valid read data.
    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: (grant == GRANT_LOAD), rob_ix: lb_rob_ix_in};
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign fifo_push_data = '{rob_ix: tag_q[READ_LATENCY-1].rob_ix, data: mem_rdata_in};

    mem_port_arbiter_load_result_fifo #(
        .DEPTH(RESULT_FIFO_DEPTH)
    ) u_result_fifo (
        .clk      (clk_in),
        .rst      (rst_in),
        .flush    (flush_in),
        .push     (tag_q[READ_LATENCY-1].valid),
        .push_data(fifo_push_data),
        .pop      (fifo_valid && ld_accept_in),
        .valid    (fifo_valid),
        .head     (fifo_head),
        .count    (fifo_cnt)
    );

    assign ld_valid_out  = fifo_valid;
    assign ld_rob_ix_out = fifo_valid ? fifo_head.rob_ix : '0;
    assign ld_data_out   = fifo_valid ? fifo_head.data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a queue-based reference model.
module tb_mem_port_arbiter;

    localparam int unsigned RL    = 2;
    localparam int unsigned AW    = 12;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXS  = 3;
    localparam int unsigned WORDS = 1 << AW;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          lb_valid_in;
    logic [31:0]   lb_addr_in;
    logic [2:0]    lb_rob_ix_in;
    logic          lb_read_out;
    logic          st_valid_in;
    logic [31:0]   st_addr_in;
    logic [31:0]   st_data_in;
    logic          st_ack_out;
    logic          flush_in;
    logic [AW-1:0] mem_addr_out;
    logic          mem_we_out;
    logic [31:0]   mem_wdata_out;
    logic [31:0]   mem_rdata_in;
    logic          ld_valid_out;
    logic [2:0]    ld_rob_ix_out;
    logic [31:0]   ld_data_out;
    logic          ld_accept_in;

    mem_port_arbiter #(
        .READ_LATENCY(RL), .ADDR_WIDTH(AW), .RESULT_FIFO_DEPTH(DEPTH), .MAX_STORE_STREAK(MAXS)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .lb_valid_in(lb_valid_in), .lb_addr_in(lb_addr_in), .lb_rob_ix_in(lb_rob_ix_in),
        .lb_read_out(lb_read_out),
        .st_valid_in(st_valid_in), .st_addr_in(st_addr_in), .st_data_in(st_data_in),
        .st_ack_out(st_ack_out), .flush_in(flush_in),
        .mem_addr_out(mem_addr_out), .mem_we_out(mem_we_out), .mem_wdata_out(mem_wdata_out),
        .mem_rdata_in(mem_rdata_in),
        .ld_valid_out(ld_valid_out), .ld_rob_ix_out(ld_rob_ix_out), .ld_data_out(ld_data_out),
        .ld_accept_in(ld_accept_in)
    );

    always #5 clk_in = ~clk_in;

    // BRAM with a fixed read latency of RL cycles.
    logic [31:0] bram [WORDS];
    logic [31:0] rd_pipe [RL];
    always @(posedge clk_in) begin
        if (mem_we_out) bram[mem_addr_out] <= mem_wdata_out;
        rd_pipe[0] <= bram[mem_addr_out];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata_in = rd_pipe[RL-1];

    typedef struct { logic [2:0] rob; logic [31:0] data; int due; } flight_t;
    typedef struct { logic [2:0] rob; logic [31:0] data; } result_t;

    flight_t       m_flight[$];
    result_t       m_fifo[$];
    logic [31:0]   m_mem [WORDS];
    int            m_streak = 0;
    logic [AW-1:0] m_last = '0;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare DUT with the model, advance the model.
    task automatic step(input logic lbv, input logic [31:0] la, input logic [2:0] lr,
                        input logic stv, input logic [31:0] sa, input logic [31:0] sd,
                        input logic fl, input logic acc, input logic rs);
        logic          elig, g_ld, g_st;
        logic [AW-1:0] lw, sw;
        result_t       r;
        flight_t       f;
        @(posedge clk_in);
        #1;
        lb_valid_in = lbv; lb_addr_in = la; lb_rob_ix_in = lr;
        st_valid_in = stv; st_addr_in = sa; st_data_in = sd;
        flush_in = fl; ld_accept_in = acc; rst_in = rs;
        @(negedge clk_in);
        lw = la[AW+1:2];
        sw = sa[AW+1:2];
        elig = lbv && !fl && ((m_flight.size() + m_fifo.size()) < DEPTH);
        g_ld = elig && (!stv || (m_streak == MAXS));
        g_st = stv && !g_ld;
        check("lb_read_out", 32'(lb_read_out), 32'(g_ld));
        check("st_ack_out", 32'(st_ack_out), 32'(g_st));
        check("mem_we_out", 32'(mem_we_out), 32'(g_st));
        check("mem_addr_out", 32'(mem_addr_out), 32'(g_st ? sw : (g_ld ? lw : m_last)));
        if (g_st) check("mem_wdata_out", mem_wdata_out, sd);
        check("ld_valid_out", 32'(ld_valid_out), 32'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) begin
            check("ld_rob_ix_out", 32'(ld_rob_ix_out), 32'(m_fifo[0].rob));
            check("ld_data_out", ld_data_out, m_fifo[0].data);
        end
        if (rs) begin
            m_flight.delete();
            m_fifo.delete();
            m_streak = 0;
            m_last = '0;
        end else begin
            if (g_st) begin
                m_mem[sw] = sd;
                m_last = sw;
            end
            if (g_ld) m_last = lw;
            if (!elig || g_ld) m_streak = 0;
            else if (g_st && m_streak < MAXS) m_streak++;
            if (fl) begin
                m_flight.delete();
                m_fifo.delete();
            end else begin
                if (m_fifo.size() != 0 && acc) m_fifo.delete(0);
                while (m_flight.size() != 0 && m_flight[0].due == cyc) begin
                    r.rob = m_flight[0].rob;
                    r.data = m_flight[0].data;
                    m_fifo.push_back(r);
                    m_flight.delete(0);
                end
                if (g_ld) begin
                    f.rob = lr; f.data = m_mem[lw]; f.due = cyc + RL;
                    m_flight.push_back(f);
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic acc);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0, acc, 1'b0);
    endtask

    initial begin
        int          grants;
        logic        rs, lbv, stv, fl, acc;
        logic [31:0] la, sa, sd;
        logic [2:0]  lr;

        for (int i = 0; i < WORDS; i++) begin
            m_mem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        end
        m_mem[16] = 32'hDEAD_BEEF;
        for (int i = 0; i < WORDS; i++) bram[i] = m_mem[i];
        for (int i = 0; i < RL; i++) rd_pipe[i] = '0;
        rst_in = 1'b1; lb_valid_in = 1'b0; lb_addr_in = '0; lb_rob_ix_in = '0;
        st_valid_in = 1'b0; st_addr_in = '0; st_data_in = '0; flush_in = 1'b0; ld_accept_in = 1'b0;

        // reset state
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("rst_ld_valid", 32'(ld_valid_out), 32'd0);
        check("rst_mem_addr", 32'(mem_addr_out), 32'd0);
        check("rst_mem_we", 32'(mem_we_out), 32'd0);
        check("rst_ld_data", ld_data_out, 32'd0);
        idle(1, 1'b1);

        // single load of word 16
        step(1, 32'h40, 3'd5, 0, 0, 0, 0, 1, 0);
        check("single_addr", 32'(mem_addr_out), 32'd16);
        check("single_grant", 32'(lb_read_out), 32'd1);
        idle(2, 1'b1);
        check("single_not_early", 32'(ld_valid_out), 32'd0);
        idle(1, 1'b1);
        check("single_valid", 32'(ld_valid_out), 32'd1);
        check("single_rob", 32'(ld_rob_ix_out), 32'd5);
        check("single_data", ld_data_out, 32'hDEAD_BEEF);
        idle(2, 1'b1);

        // store then load the same word
        step(0, 0, 0, 1, 32'h80, 32'h1234_5678, 0, 1, 0);
        check("st_ack", 32'(st_ack_out), 32'd1);
        check("st_addr", 32'(mem_addr_out), 32'd32);
        step(1, 32'h80, 3'd2, 0, 0, 0, 0, 1, 0);
        idle(3, 1'b1);
        check("raw_valid", 32'(ld_valid_out), 32'd1);
        check("raw_data", ld_data_out, 32'h1234_5678);
        idle(2, 1'b1);

        // starvation guard: three stores, then the load
        for (int k = 0; k < 8; k++) begin
            step(1, 32'h100 + 32'(k * 4), 3'(k), 1, 32'h200 + 32'(k * 4), 32'(k), 0, 1, 0);
            check("starve_load", 32'(lb_read_out), 32'((k % 4) == 3));
            check("starve_store", 32'(st_ack_out), 32'((k % 4) != 3));
        end
        idle(4, 1'b1);

        // credit backpressure
        grants = 0;
        for (int k = 0; k < 8; k++) begin
            step(1, 32'h300 + 32'(k * 4), 3'(k), 0, 0, 0, 0, 0, 0);
            grants += int'(lb_read_out);
        end
        check("bp_grants", 32'(grants), 32'd4);
        step(1, 32'h320, 3'd6, 0, 0, 0, 0, 1, 0);
        check("bp_pop_no_credit", 32'(lb_read_out), 32'd0);
        step(1, 32'h320, 3'd6, 0, 0, 0, 0, 0, 0);
        check("bp_fifth_grant", 32'(lb_read_out), 32'd1);
        idle(8, 1'b1);

        // flush with two loads in flight and one buffered, plus a committed store
        for (int k = 0; k < 3; k++) step(1, 32'h400 + 32'(k * 4), 3'(k + 1), 0, 0, 0, 0, 0, 0);
        step(1, 32'h40C, 3'd4, 1, 32'h500, 32'hA5A5_A5A5, 1, 0, 0);
        check("flush_buffered", 32'(ld_valid_out), 32'd1);
        check("flush_store_ack", 32'(st_ack_out), 32'd1);
        check("flush_no_load", 32'(lb_read_out), 32'd0);
        for (int k = 0; k < 4; k++) begin
            idle(1, 1'b0);
            check("flush_quiet", 32'(ld_valid_out), 32'd0);
        end
        grants = 0;
        for (int k = 0; k < 4; k++) begin
            step(1, 32'h600 + 32'(k * 4), 3'(k), 0, 0, 0, 0, 0, 0);
            grants += int'(lb_read_out);
        end
        check("flush_credit_back", 32'(grants), 32'd4);
        idle(8, 1'b1);

        // reset while a load is in flight
        step(1, 32'h40, 3'd6, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int k = 0; k < 4; k++) begin
            idle(1, 1'b1);
            check("rstmid_valid", 32'(ld_valid_out), 32'd0);
            check("rstmid_addr", 32'(mem_addr_out), 32'd0);
        end

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rs  = ($urandom_range(0, 299) == 0);
            lbv = !rs && ($urandom_range(0, 99) < 60);
            stv = !rs && ($urandom_range(0, 99) < 45);
            fl  = !rs && ($urandom_range(0, 49) == 0);
            acc = ($urandom_range(0, 99) < 65);
            la  = ($urandom() & 32'hFFFF_C003) | (32'($urandom_range(0, 15)) << 2);
            sa  = ($urandom() & 32'hFFFF_C003) | (32'($urandom_range(0, 15)) << 2);
            sd  = $urandom();
            lr  = 3'($urandom_range(0, 7));
            step(lbv, la, lr, stv, sa, sd, fl, acc, rs);
        end
        idle(10, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory BRAM port between two requesters:
  - the load buffer (speculative loads);
  - the ROB store-commit path (in-order retired stores).
- Tracks loads in flight through the fixed BRAM read latency and buffers their results in a small FIFO toward the CDB.
- Sits between load_buffer / reorder_buffer and the data BRAM. Its load grant drives the load buffer's read_in.

Parameters:
- READ_LATENCY, 2, cycles from address presented to mem_rdata_in valid (1..4).
- ADDR_WIDTH, 12, BRAM word-address width.
- RESULT_FIFO_DEPTH, 4, load-result FIFO entries; also the cap on (in-flight + buffered) loads.
- MAX_STORE_STREAK, 3, consecutive store grants allowed while an eligible load waits.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- lb_valid_in  input  1  load buffer has an issuable load
- lb_addr_in  input  32  load byte address
- lb_rob_ix_in  input  3  ROB index of the load
- lb_read_out  output  1  load granted this cycle (to load_buffer read_in)
- st_valid_in  input  1  ROB has a committed store pending
- st_addr_in  input  32  store byte address
- st_data_in  input  32  store data
- st_ack_out  output  1  store written this cycle
- flush_in  input  1  mispredict flush; squash all loads
- mem_addr_out  output  ADDR_WIDTH  BRAM word address
- mem_we_out  output  1  BRAM write enable
- mem_wdata_out  output  32  BRAM write data
- mem_rdata_in  input  32  BRAM read data
- ld_valid_out  output  1  load result available
- ld_rob_ix_out  output  3  ROB index of the result
- ld_data_out  output  32  loaded word
- ld_accept_in  input  1  CDB consumed the result this cycle

Behaviour:
- Clock is clk_in; reset is rst_in, synchronous and active-high.
- Reset: pipeline valids 0, FIFO empty, streak counter 0. All outputs 0.
- Addressing: word access only. mem_addr_out = addr[ADDR_WIDTH+1:2]; addr[1:0] and upper bits are ignored.
- Load eligibility: lb_valid_in && !flush_in && (inflight_cnt + fifo_cnt < RESULT_FIFO_DEPTH).
  - Counts are taken at the start of the cycle.
  - A same-cycle FIFO pop grants no credit.
- Arbitration is combinational, at most one grant per cycle:
  - Store only valid -> store granted.
  - Eligible load only -> load granted.
  - Both present -> store wins, unless streak == MAX_STORE_STREAK, in which case the load wins.
- Streak counter:
  - +1 on a store grant while an eligible load was denied.
  - Cleared on any load grant, or on any cycle with no eligible load.
  - Saturates at MAX_STORE_STREAK.
- Store grant cycle:
  - mem_we_out=1; mem_addr_out/mem_wdata_out from st_*; st_ack_out=1.
  - The ROB advances its head on st_ack_out.
- Load grant cycle:
  - mem_we_out=0; mem_addr_out from lb_addr_in; lb_read_out=1.
  - {valid, rob_ix} enters a READ_LATENCY-deep shift register.
- Idle cycle: mem_we_out=0, mem_addr_out holds the last value.
- Result capture:
  - A load granted in cycle T has mem_rdata_in sampled at the end of cycle T+READ_LATENCY and pushed to the FIFO.
  - ld_valid_out rises in T+READ_LATENCY+1.
  - Minimum grant-to-result latency is READ_LATENCY+1.
- FIFO:
  - Show-ahead; ld_* reflects the head entry.
  - Pop occurs when ld_valid_out && ld_accept_in.
  - Push and pop in the same cycle are both allowed.
  - Overflow is impossible by credit; overflow is an assertion.
  - Results leave in grant order.
- Flush:
  - In the flush cycle: no load grant.
  - At that edge: all shift-register valids cleared, FIFO emptied. ld_valid_out is 0 the next cycle.
  - A store grant in the flush cycle still proceeds, since the store is committed.
- Reset mid-operation: in-flight loads are dropped and no result is emitted for them.

Decomposition:
- Shared package holds:
  - ROB_IX_WIDTH=3 (matches reorder_buffer);
  - typedef load_tag_t {valid, rob_ix};
  - typedef mem_grant_e {GRANT_NONE, GRANT_LOAD, GRANT_STORE}.
- Sub-module load_result_fifo: parameterised depth; push/pop/count/flush.

Test Plan:
- Single load: lb_valid_in with addr 0x40, rob_ix 5, BRAM word 16 = 0xDEADBEEF, grant at T -> mem_addr_out=16 at T; ld_valid_out at T+3 with rob_ix 5, data 0xDEADBEEF.
- Store then load: store 0x12345678 to 0x80, then load 0x80 one cycle later -> st_ack_out at T; load returns 0x12345678.
- Starvation guard: st_valid_in and lb_valid_in held high -> store granted 3 cycles, load granted in cycle 4, then stores resume.
- Credit backpressure: ld_accept_in=0, 6 loads offered -> only 4 lb_read_out pulses; 5th granted the cycle after the first accepted pop.
- Flush: 2 loads in flight plus 1 buffered, flush_in pulsed together with a store -> no ld_valid_out afterward; store still acked; counts return to 0.
- Reset mid-flight: rst_in asserted at T+1 after a load grant -> all outputs 0 from T+2; no result emitted.
